// File: rtl/decode_pkg.sv
// decode_pkg: shared opcode constants, immediate-format enum and the
// control half of a buffered decode entry for decode_2_queue.
// Optional build macro: DECODE2_ILLEGAL_TRAP_EN (adds the stored illegal flag).
package decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } imm_fmt_e;

    // Width-independent part of an entry; pc and imm are XLEN-sized and are
    // wrapped around this in the top level.
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [6:0] funct7;
`ifdef DECODE2_ILLEGAL_TRAP_EN
        logic       illegal;
`endif
    } decode_ctrl_t;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
        imm_fmt_e f;
        case (opcode)
            OP_R:                                        f = FMT_R;
            OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: f = FMT_I;
            OP_STORE:                                    f = FMT_S;
            OP_BRANCH:                                   f = FMT_B;
            OP_LUI, OP_AUIPC:                            f = FMT_U;
            OP_JAL:                                      f = FMT_J;
            default:                                     f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/decode_2_queue_if.sv
// decode_2_queue_if: upstream (DECODE1) and downstream (DECODE2) handshake
// bundle plus FLUSH. slave = the queue, master = whoever drives it.
interface decode_2_queue_if #(parameter int XLEN = 32);
    logic            FLUSH;
    logic            DECODE1_VALID;
    logic            DECODE1_READY;
    logic [XLEN-1:0] DECODE1_PC;
    logic [6:0]      DECODE1_OPCODE;
    logic [4:0]      DECODE1_RD;
    logic [2:0]      DECODE1_FUNCT3;
    logic [6:0]      DECODE1_FUNCT7;
    logic [XLEN-1:0] DECODE1_IMM_I;
    logic [XLEN-1:0] DECODE1_IMM_S;
    logic [XLEN-1:0] DECODE1_IMM_B;
    logic [XLEN-1:0] DECODE1_IMM_U;
    logic [XLEN-1:0] DECODE1_IMM_J;
    logic            DECODE2_VALID;
    logic            DECODE2_READY;
    logic [XLEN-1:0] DECODE2_PC;
    logic [6:0]      DECODE2_OPCODE;
    logic [4:0]      DECODE2_RD;
    logic [2:0]      DECODE2_FUNCT3;
    logic [6:0]      DECODE2_FUNCT7;
    logic [XLEN-1:0] DECODE2_IMM;
    logic            DECODE2_ILLEGAL;

    modport master (
        output FLUSH, DECODE1_VALID, DECODE1_PC, DECODE1_OPCODE, DECODE1_RD,
               DECODE1_FUNCT3, DECODE1_FUNCT7, DECODE1_IMM_I, DECODE1_IMM_S,
               DECODE1_IMM_B, DECODE1_IMM_U, DECODE1_IMM_J, DECODE2_READY,
        input  DECODE1_READY, DECODE2_VALID, DECODE2_PC, DECODE2_OPCODE,
               DECODE2_RD, DECODE2_FUNCT3, DECODE2_FUNCT7, DECODE2_IMM,
               DECODE2_ILLEGAL
    );

    modport slave (
        input  FLUSH, DECODE1_VALID, DECODE1_PC, DECODE1_OPCODE, DECODE1_RD,
               DECODE1_FUNCT3, DECODE1_FUNCT7, DECODE1_IMM_I, DECODE1_IMM_S,
               DECODE1_IMM_B, DECODE1_IMM_U, DECODE1_IMM_J, DECODE2_READY,
        output DECODE1_READY, DECODE2_VALID, DECODE2_PC, DECODE2_OPCODE,
               DECODE2_RD, DECODE2_FUNCT3, DECODE2_FUNCT7, DECODE2_IMM,
               DECODE2_ILLEGAL
    );
endinterface

// File: rtl/decode_2_fifo.sv
// decode_2_fifo: DEPTH x W synchronous FIFO with flush. Flush beats push/pop.
// Pushes when full and pops when empty are ignored.
module decode_2_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, empty, wr_en, rd_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && !full && !flush;
    assign rd_en = pop && !empty && !flush;
    assign rdata = mem[rd_ptr];

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/decode_2_queue.sv
// decode_2_queue: second decode stage. Selects the immediate by opcode
// format on the way in, buffers entries in decode_2_fifo, masks outputs
// to zero while empty.
// Optional build macro: DECODE2_ILLEGAL_TRAP_EN -- when defined, illegal
// opcodes are queued and flagged; otherwise they are accepted and dropped.
module decode_2_queue
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RST,
    decode_2_queue_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        decode_ctrl_t    ctrl;
        logic [XLEN-1:0] imm;
    } entry_t;

    imm_fmt_e        fmt;
    logic            illegal;
    entry_t          wr_entry, head;
    logic [CNT_W-1:0] count;
    logic            push, pop, head_valid;

    // Immediate select and illegal detection on the incoming instruction.
    always_comb begin
        fmt     = imm_fmt(bus.DECODE1_OPCODE);
        illegal = (fmt == FMT_BAD);
        wr_entry             = '0;
        wr_entry.pc          = bus.DECODE1_PC;
        wr_entry.ctrl.opcode = bus.DECODE1_OPCODE;
        wr_entry.ctrl.rd     = bus.DECODE1_RD;
        wr_entry.ctrl.funct3 = bus.DECODE1_FUNCT3;
        wr_entry.ctrl.funct7 = bus.DECODE1_FUNCT7;
`ifdef DECODE2_ILLEGAL_TRAP_EN
        wr_entry.ctrl.illegal = illegal;
`endif
        case (fmt)
            FMT_I:   wr_entry.imm = bus.DECODE1_IMM_I;
            FMT_S:   wr_entry.imm = bus.DECODE1_IMM_S;
            FMT_B:   wr_entry.imm = bus.DECODE1_IMM_B;
            FMT_U:   wr_entry.imm = bus.DECODE1_IMM_U;
            FMT_J:   wr_entry.imm = bus.DECODE1_IMM_J;
            default: wr_entry.imm = '0;
        endcase
    end

    // Ready depends only on occupancy and FLUSH, never on DECODE1_VALID.
    assign bus.DECODE1_READY = (count != CNT_W'(DEPTH)) && !bus.FLUSH;
    assign head_valid        = (count != '0);
    assign pop               = head_valid && bus.DECODE2_READY;

`ifdef DECODE2_ILLEGAL_TRAP_EN
    assign push = bus.DECODE1_VALID && bus.DECODE1_READY;
`else
    // Illegal opcodes complete the handshake but are never written.
    assign push = bus.DECODE1_VALID && bus.DECODE1_READY && !illegal;
`endif

    decode_2_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .flush (bus.FLUSH),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .count (count)
    );

    // Drive head entry outward, forced to zero while the queue is empty.
    always_comb begin
        bus.DECODE2_VALID   = head_valid;
        bus.DECODE2_PC      = '0;
        bus.DECODE2_OPCODE  = '0;
        bus.DECODE2_RD      = '0;
        bus.DECODE2_FUNCT3  = '0;
        bus.DECODE2_FUNCT7  = '0;
        bus.DECODE2_IMM     = '0;
        bus.DECODE2_ILLEGAL = 1'b0;
        if (head_valid) begin
            bus.DECODE2_PC     = head.pc;
            bus.DECODE2_OPCODE = head.ctrl.opcode;
            bus.DECODE2_RD     = head.ctrl.rd;
            bus.DECODE2_FUNCT3 = head.ctrl.funct3;
            bus.DECODE2_FUNCT7 = head.ctrl.funct7;
            bus.DECODE2_IMM    = head.imm;
`ifdef DECODE2_ILLEGAL_TRAP_EN
            bus.DECODE2_ILLEGAL = head.ctrl.illegal;
`endif
        end
    end
endmodule

// File: tb/tb_decode_2_queue.sv
// tb_decode_2_queue: scoreboard bench for decode_2_queue (DEPTH=2).
// Honours DECODE2_ILLEGAL_TRAP_EN when the build defines it.
module tb_decode_2_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
`ifdef DECODE2_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;
    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    decode_2_queue_if #(.XLEN(XLEN)) bus();

    decode_2_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one upstream instruction; the five immediates are all distinct.
    task automatic send(input logic v, input logic [31:0] pc, input logic [6:0] op,
                        input logic [31:0] immi);
        bus.DECODE1_VALID  = v;
        bus.DECODE1_PC     = pc;
        bus.DECODE1_OPCODE = op;
        bus.DECODE1_RD     = 5'($urandom);
        bus.DECODE1_FUNCT3 = 3'($urandom);
        bus.DECODE1_FUNCT7 = 7'($urandom);
        bus.DECODE1_IMM_I  = immi;
        bus.DECODE1_IMM_S  = immi ^ 32'h0000_0011;
        bus.DECODE1_IMM_B  = immi ^ 32'h0000_0022;
        bus.DECODE1_IMM_U  = immi ^ 32'h0000_0033;
        bus.DECODE1_IMM_J  = immi ^ 32'h0000_0044;
    endtask

    // One clock: check outputs against the scoreboard, then account for the
    // handshakes that will happen on the coming edge.
    task automatic cycle();
        exp_t e, d;
        logic exp_rdy, exp_vld, acc, pop_now;
        #1;
        exp_rdy = (sb.size() != DEPTH) && !bus.FLUSH;
        exp_vld = (sb.size() != 0);
        chk("dec1_ready", bus.DECODE1_READY, exp_rdy);
        chk("dec2_valid", bus.DECODE2_VALID, exp_vld);
        if (exp_vld) begin
            e = sb[0];
            chk("head_pc",  bus.DECODE2_PC,      e.pc);
            chk("head_op",  bus.DECODE2_OPCODE,  e.op);
            chk("head_rd",  bus.DECODE2_RD,      e.rd);
            chk("head_f3",  bus.DECODE2_FUNCT3,  e.f3);
            chk("head_f7",  bus.DECODE2_FUNCT7,  e.f7);
            chk("head_imm", bus.DECODE2_IMM,     e.imm);
            chk("head_ill", bus.DECODE2_ILLEGAL, e.ill);
        end else begin
            chk("idle_pc",  bus.DECODE2_PC,      0);
            chk("idle_imm", bus.DECODE2_IMM,     0);
            chk("idle_ill", bus.DECODE2_ILLEGAL, 0);
        end
        acc     = bus.DECODE1_VALID && exp_rdy;
        pop_now = exp_vld && bus.DECODE2_READY;
        e.pc  = bus.DECODE1_PC;
        e.op  = bus.DECODE1_OPCODE;
        e.rd  = bus.DECODE1_RD;
        e.f3  = bus.DECODE1_FUNCT3;
        e.f7  = bus.DECODE1_FUNCT7;
        e.ill = 1'b0;
        e.imm = '0;
        case (bus.DECODE1_OPCODE)
            7'h33:                             e.imm = '0;
            7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: e.imm = bus.DECODE1_IMM_I;
            7'h23:                             e.imm = bus.DECODE1_IMM_S;
            7'h63:                             e.imm = bus.DECODE1_IMM_B;
            7'h37, 7'h17:                      e.imm = bus.DECODE1_IMM_U;
            7'h6F:                             e.imm = bus.DECODE1_IMM_J;
            default:                           e.ill = 1'b1;
        endcase
        if (bus.FLUSH) sb.delete();
        else begin
            if (pop_now) d = sb.pop_front();
            if (acc && (!e.ill || TRAP)) sb.push_back(e);
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        logic [6:0] wrap_ops [5];
        wrap_ops = '{7'b0100011, 7'b0110111, 7'b0010111, 7'b0000011, 7'b1100111};
        RST = 1'b1;
        bus.FLUSH = 1'b0;
        bus.DECODE2_READY = 1'b0;
        send(1'b0, 32'h0, 7'h0, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        #1;
        chk("rst_valid", bus.DECODE2_VALID, 0);
        chk("rst_ready", bus.DECODE1_READY, 1);
        chk("rst_pc",    bus.DECODE2_PC,    0);
        chk("rst_imm",   bus.DECODE2_IMM,   0);
        @(negedge CLK);
        RST = 1'b0;

        // ADDI through an always-ready consumer: one cycle of valid.
        bus.DECODE2_READY = 1'b1;
        send(1'b1, 32'h100, 7'b0010011, 32'hFFFF_FFFC);
        cycle();
        send(1'b0, 32'h0, 7'h0, 32'h0);
        cycle();
        cycle();

        // Back-pressure: third entry must be held upstream.
        bus.DECODE2_READY = 1'b0;
        send(1'b1, 32'h200, 7'b1100011, 32'h0000_0800);
        cycle();
        send(1'b1, 32'h204, 7'b1101111, 32'h0001_0000);
        cycle();
        send(1'b1, 32'h208, 7'b0110011, 32'h1234_5678);
        cycle();
        cycle();
        cycle();

        // Drain in order, then pointer wrap via push/pop pairs.
        send(1'b0, 32'h0, 7'h0, 32'h0);
        bus.DECODE2_READY = 1'b1;
        repeat (4) cycle();
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 32'h300 + 32'(i * 4), wrap_ops[i], $urandom);
            cycle();
        end
        send(1'b0, 32'h0, 7'h0, 32'h0);
        cycle();
        cycle();

        // Flush with two buffered and a simultaneous push.
        bus.DECODE2_READY = 1'b0;
        send(1'b1, 32'h400, 7'b1110011, 32'h0000_0ABC);
        cycle();
        send(1'b1, 32'h404, 7'b0001111, 32'h0000_0DEF);
        cycle();
        send(1'b1, 32'h408, 7'b1101111, 32'h0000_4444);
        bus.FLUSH = 1'b1;
        cycle();
        cycle();
        bus.FLUSH = 1'b0;
        send(1'b0, 32'h0, 7'h0, 32'h0);
        cycle();

        // Illegal opcode.
        send(1'b1, 32'h500, 7'b0000000, 32'h0000_5555);
        cycle();
        send(1'b0, 32'h0, 7'h0, 32'h0);
        cycle();
        bus.DECODE2_READY = 1'b1;
        cycle();
        cycle();

        // Asynchronous reset mid-stream, away from any clock edge.
        bus.DECODE2_READY = 1'b0;
        send(1'b1, 32'h600, 7'b0010011, 32'h0000_0600);
        cycle();
        send(1'b1, 32'h604, 7'b0110011, 32'h0000_0604);
        cycle();
        send(1'b0, 32'h0, 7'h0, 32'h0);
        #3 RST = 1'b1;
        #1;
        chk("arst_valid", bus.DECODE2_VALID, 0);
        chk("arst_ready", bus.DECODE1_READY, 1);
        chk("arst_pc",    bus.DECODE2_PC,    0);
        sb.delete();
        @(negedge CLK);
        RST = 1'b0;

        // LUI after reset must carry IMM_U.
        bus.DECODE2_READY = 1'b1;
        send(1'b1, 32'h700, 7'b0110111, 32'hABCD_E000);
        cycle();
        send(1'b0, 32'h0, 7'h0, 32'h0);
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/decode_2_queue.md
Name: decode_2_queue

Overview:
- Parametrised successor to the second decode stage, placed between decode stage 1 and the execute unit.
- Selects the immediate by opcode format (R/I/S/B/U/J) at enqueue time.
- Buffers decoded instructions in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Adds back-pressure, pipeline flush and illegal-opcode flagging, none of which exist in the previous stage.

Parameters:
- XLEN, 32, width of PC and immediates.
- DEPTH, 2, FIFO entries; power of two, >=2.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- FLUSH  in  1  discard all buffered and incoming entries
- DECODE1_VALID  in  1  upstream entry valid
- DECODE1_READY  out  1  stage can accept
- DECODE1_PC  in  XLEN  instruction PC
- DECODE1_OPCODE  in  7  opcode
- DECODE1_RD  in  5  destination register
- DECODE1_FUNCT3  in  3  funct3
- DECODE1_FUNCT7  in  7  funct7
- DECODE1_IMM_I / _S / _B / _U / _J  in  XLEN each  pre-extended immediates
- DECODE2_VALID  out  1  head entry valid
- DECODE2_READY  in  1  execute accepts head
- DECODE2_PC  out  XLEN  head PC
- DECODE2_OPCODE  out  7  head opcode
- DECODE2_RD  out  5  head rd
- DECODE2_FUNCT3  out  3  head funct3
- DECODE2_FUNCT7  out  7  head funct7
- DECODE2_IMM  out  XLEN  selected immediate
- DECODE2_ILLEGAL  out  1  head opcode unsupported (feature-dependent)

Behaviour:
- Clock and reset: single clock CLK. RST is asynchronous and active-high; it clears write pointer, read pointer and count to 0 immediately.
- Immediate select (combinational, before storage):
  - 0110011 -> 0
  - 1100111, 0000011, 0010011, 0001111, 1110011 -> IMM_I
  - 0100011 -> IMM_S
  - 1100011 -> IMM_B
  - 0110111, 0010111 -> IMM_U
  - 1101111 -> IMM_J
  - any other opcode is illegal; imm = 0
- Storage: each entry holds {pc, opcode, rd, funct3, funct7, imm, illegal}.
- Counters: pointers are $clog2(DEPTH) bits and wrap naturally. Count is $clog2(DEPTH)+1 bits.
- Ready and valid:
  - DECODE1_READY = (count != DEPTH) && !FLUSH. It is combinational from registers and FLUSH only.
  - DECODE2_VALID = (count != 0).
  - All DECODE2_* data outputs are 0 while DECODE2_VALID=0. DECODE2_VALID and data are therefore 0 out of reset.
- Push: DECODE1_VALID && DECODE1_READY (subject to the optional feature). Pop: DECODE2_VALID && DECODE2_READY.
- Latency: an entry pushed at edge N is visible at the outputs after edge N. There is no combinational bypass from DECODE1 to DECODE2.
- Simultaneous push and pop:
  - Count unchanged; both pointers advance.
  - When full, READY=0, so no push can coincide with a pop.
- Flush: FLUSH=1 at edge N sets count and both pointers to 0 after N. Any push or pop in that cycle is ignored. DECODE2_VALID=0 in cycle N+1.
- Flush has priority over push and pop. FLUSH held high keeps the queue empty.
- Outputs must hold stable while DECODE2_VALID=1 and DECODE2_READY=0.

Optional Feature:
- Macro: DECODE2_ILLEGAL_TRAP_EN.
- Defined: illegal opcodes are enqueued with illegal=1 and imm=0. DECODE2_ILLEGAL reflects the head entry, and execute raises the trap.
- Undefined: illegal opcodes are accepted (handshake completes, DECODE1_READY unaffected) but not written; they are silently dropped. DECODE2_ILLEGAL is tied 0.

Decomposition:
- Package decode_pkg holds:
  - opcode constants (OP_R, OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL)
  - imm-format enum
  - the entry struct typedef
- One natural sub-module: decode_2_fifo, a generic DEPTH x W synchronous FIFO with flush. The top level keeps the immediate select, illegal detection and output masking.

Test Plan:
- Reset then push ADDI (opcode 0010011, IMM_I=0xFFFFFFFC, PC=0x100) with DECODE2_READY=1 -> next cycle VALID=1, IMM=0xFFFFFFFC, PC=0x100, one-cycle valid.
- DECODE2_READY=0, push 3 entries with DEPTH=2 -> DECODE1_READY drops after the 2nd push. The 3rd entry is held upstream. Head stays entry 1 unchanged.
- Full queue, then READY=1 for 4 cycles -> entries pop in order B (IMM_B), J (IMM_J), then VALID=0. Wrap checked with 5 further push/pop pairs.
- Two entries buffered, FLUSH=1 with a simultaneous DECODE1_VALID -> next cycle VALID=0 and count 0. The flushed-cycle input is never output.
- Push opcode 0000000 -> with DECODE2_ILLEGAL_TRAP_EN: VALID=1, ILLEGAL=1, IMM=0. Without it: VALID stays 0.
- Assert RST mid-stream, asynchronously off-edge -> VALID=0 and READY=1 immediately. A subsequent LUI (0110111) outputs IMM_U.
